// File: rtl/buf_stream_ctrl.sv
// buf_stream_ctrl
//   Sequencer for one frame through the expansion buffer -> compute unit ->
//   contraction buffer path. Only the buffers' addr/en/mode controls are
//   driven here; data words bypass this block.
//
//   Optional feature: define BUF_STREAM_CTRL_TIMEOUT_EN to abort WAIT after
//   TIMEOUT cycles without cu_done (sets sticky timeout_err).
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   flush             synchronous abort to FILL, counters cleared
//   in_val / in_rdy   input stream handshake
//   exp_addr/en/mode  expansion buffer control (mode 1=SIN, 0=POUT)
//   cu_start/cu_done  compute unit start pulse / completion
//   con_addr/en/mode  contraction buffer control (mode 1=PIN, 0=SOUT)
//   out_val / out_rdy output stream handshake
//   timeout_err       sticky WAIT-timeout abort flag
module buf_stream_ctrl #(
  parameter int unsigned EXPANSION = 8,
  parameter int unsigned CONTRACT  = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_val,
  output logic        in_rdy,
  output logic [31:0] exp_addr,
  output logic        exp_en,
  output logic        exp_mode,
  output logic        cu_start,
  input  logic        cu_done,
  output logic [31:0] con_addr,
  output logic        con_en,
  output logic        con_mode,
  output logic        out_val,
  input  logic        out_rdy,
  output logic        timeout_err
);

  if (EXPANSION < 1 || EXPANSION > 8) begin : g_bad_expansion
    $error("EXPANSION must be 1..8");
  end
  if (CONTRACT < 1 || CONTRACT > 8) begin : g_bad_contract
    $error("CONTRACT must be 1..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  localparam logic [31:0] FILL_LAST  = 32'(EXPANSION - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(CONTRACT - 1);

  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] fill_cnt, fill_cnt_nx;
  logic [31:0] drain_cnt, drain_cnt_nx;
  logic        accept, take, expired;

  // Moore decode; only in_rdy (flush) and exp_en (in_val) see inputs.
  assign in_rdy   = (state == FILL) && !flush;
  assign accept   = in_val && in_rdy;
  assign exp_en   = accept;
  assign exp_mode = (state == FILL);
  assign exp_addr = fill_cnt;
  assign cu_start = (state == START);
  assign out_val  = (state == DRAIN);
  assign con_en   = (state == DRAIN);
  assign con_mode = (state != DRAIN);
  assign con_addr = drain_cnt;
  assign take     = out_val && out_rdy;

`ifdef BUF_STREAM_CTRL_TIMEOUT_EN
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  logic [31:0] wait_cnt, wait_cnt_nx;
  logic        err_q, err_nx;

  // cu_done on the final WAIT cycle wins over the abort.
  assign expired     = (state == WAIT) && !cu_done && (wait_cnt == WAIT_LAST);
  assign timeout_err = err_q;

  always_comb begin
    wait_cnt_nx = '0;
    err_nx      = err_q;
    if (flush) begin
      err_nx = 1'b0;
    end else begin
      if ((state == WAIT) && !cu_done && !expired) wait_cnt_nx = wait_cnt + 32'd1;
      if (expired) err_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nx;
      err_q    <= err_nx;
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    fill_cnt_nx  = fill_cnt;
    drain_cnt_nx = drain_cnt;
    if (flush) begin
      state_nx     = FILL;
      fill_cnt_nx  = '0;
      drain_cnt_nx = '0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            if (fill_cnt == FILL_LAST) begin
              fill_cnt_nx = '0;
              state_nx    = START;
            end else begin
              fill_cnt_nx = fill_cnt + 32'd1;
            end
          end
        end
        START: state_nx = WAIT;
        WAIT: begin
          if (cu_done)      state_nx = DRAIN;
          else if (expired) state_nx = FILL;
        end
        DRAIN: begin
          if (take) begin
            if (drain_cnt == DRAIN_LAST) begin
              drain_cnt_nx = '0;
              state_nx     = FILL;
            end else begin
              drain_cnt_nx = drain_cnt + 32'd1;
            end
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      fill_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      fill_cnt  <= fill_cnt_nx;
      drain_cnt <= drain_cnt_nx;
    end
  end

endmodule

// File: tb/tb_buf_stream_ctrl.sv
// Testbench for buf_stream_ctrl (EXPANSION=8, CONTRACT=4, TIMEOUT=16).
// Works with BUF_STREAM_CTRL_TIMEOUT_EN defined or undefined.
module tb_buf_stream_ctrl;
  localparam int unsigned EXP = 8;
  localparam int unsigned CON = 4;
  localparam int unsigned TO  = 16;
`ifdef BUF_STREAM_CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic        clk, reset, flush, in_val, in_rdy, exp_en, exp_mode, cu_start, cu_done;
  logic        con_en, con_mode, out_val, out_rdy, timeout_err;
  logic [31:0] exp_addr, con_addr;

  buf_stream_ctrl #(.EXPANSION(EXP), .CONTRACT(CON), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_val(in_val), .in_rdy(in_rdy),
    .exp_addr(exp_addr), .exp_en(exp_en), .exp_mode(exp_mode),
    .cu_start(cu_start), .cu_done(cu_done),
    .con_addr(con_addr), .con_en(con_en), .con_mode(con_mode),
    .out_val(out_val), .out_rdy(out_rdy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] con_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every handshake must consume the next expected address.
  always @(negedge clk) begin
    if (reset) begin
      if (in_val && in_rdy) begin
        check("exp_en_on_accept", {31'd0, exp_en}, 32'd1);
        if (exp_q.size() == 0) check("exp_extra_accept", exp_q.size(), 1);
        else check("exp_addr_sb", exp_addr, exp_q.pop_front());
      end
      if (out_val && out_rdy) begin
        if (con_q.size() == 0) check("con_extra_take", con_q.size(), 1);
        else check("con_addr_sb", con_addr, con_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        fl, iv, cd, ordy;
    logic [7:0]  outs;   // {in_rdy,exp_en,exp_mode,cu_start,out_val,con_en,con_mode,timeout_err}
    logic [31:0] ea, ca;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, iv, cd, ordy, input logic [7:0] outs,
                              input logic [31:0] ea, ca);
    vec_t v;
    v.fl = fl; v.iv = iv; v.cd = cd; v.ordy = ordy; v.outs = outs; v.ea = ea; v.ca = ca;
    return v;
  endfunction

  function automatic logic [7:0] outs_now();
    return {in_rdy, exp_en, exp_mode, cu_start, out_val, con_en, con_mode, timeout_err};
  endfunction

  task automatic drive(input logic fl, iv, cd, ordy);
    flush = fl; in_val = iv; cu_done = cd; out_rdy = ordy;
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int unsigned i = 0; i < EXP; i++) exp_q.push_back(32'(i));
    for (int unsigned i = 0; i < CON; i++) con_q.push_back(32'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned k, acc, tk;

    // Full-frame vector table: 8 accepts, START, 4 idle WAIT + done, 4 takes, FILL.
    for (int unsigned i = 0; i < EXP; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'b1110_0010, 32'(i), 32'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'b0001_0010, 32'd0, 32'd0));
    for (int unsigned i = 0; i < 4; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'b0000_0010, 32'd0, 32'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0010, 32'd0, 32'd0));
    for (int unsigned i = 0; i < CON; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'b0000_1100, 32'd0, 32'(i)));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'b1010_0010, 32'd0, 32'd0));

    // Reset held 3 cycles.
    reset = 1'b0; flush = 1'b0; in_val = 1'b0; cu_done = 1'b0; out_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_outs", {24'd0, outs_now()}, {24'd0, 8'b1010_0010});
      check("rst_exp_addr", exp_addr, 32'd0);
      check("rst_con_addr", con_addr, 32'd0);
    end
    cyc();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("post_rst_cu_start", {31'd0, cu_start}, 32'd0);
    cyc();

    // Table-driven full frame.
    push_frame();
    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].cd, vecs[i].ordy);
      check($sformatf("vec%0d_outs", i), {24'd0, outs_now()}, {24'd0, vecs[i].outs});
      check($sformatf("vec%0d_exp_addr", i), exp_addr, vecs[i].ea);
      check($sformatf("vec%0d_con_addr", i), con_addr, vecs[i].ca);
      cyc();
    end

    // Backpressure on both streams.
    push_frame();
    k = 0; acc = 0;
    while (acc < EXP && k < 64) begin
      drive(1'b0, (k % 2) == 0, 1'b0, 1'b0);
      if (in_val && in_rdy) acc++;
      cyc(); k++;
    end
    check("bp_accepts", acc, EXP);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_cu_start", {31'd0, cu_start}, 32'd1);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_wait_no_val", {31'd0, out_val}, 32'd0);
    cyc();
    k = 0; tk = 0;
    while (tk < CON && k < 64) begin
      drive(1'b0, 1'b0, 1'b0, (k % 2) == 1);
      if (out_val && out_rdy) tk++;
      cyc(); k++;
    end
    check("bp_takes", tk, CON);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_back_to_fill", {30'd0, in_rdy, out_val}, 32'b10);
    cyc();

    // Spurious cu_done during FILL (word 3) and DRAIN.
    push_frame();
    for (int unsigned i = 0; i < EXP; i++) begin
      drive(1'b0, 1'b1, i == 3, 1'b0);
      check("sp_fill_rdy", {31'd0, in_rdy}, 32'd1);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("sp_cu_start", {31'd0, cu_start}, 32'd1);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("sp_drain_addr", con_addr, 32'd1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("sp_drain_addr_hold", con_addr, 32'd1);
    check("sp_drain_val", {31'd0, out_val}, 32'd1);
    cyc();
    repeat (CON - 1) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("sp_back_to_fill", {31'd0, in_rdy}, 32'd1);
    cyc();

    // Flush after 5 accepts, then a full refill, then flush during WAIT.
    push_frame();
    repeat (5) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("fl_in_rdy_low", {31'd0, in_rdy}, 32'd0);
    exp_q.delete(); con_q.delete();
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_exp_addr", exp_addr, 32'd0);
    check("fl_in_rdy", {31'd0, in_rdy}, 32'd1);
    cyc();
    push_frame();
    repeat (EXP - 1) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_no_early_start", {31'd0, cu_start}, 32'd0);
    check("fl_exp_addr7", exp_addr, 32'd7);
    cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_cu_start", {31'd0, cu_start}, 32'd1);
    cyc();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("fl_wait_no_val", {31'd0, out_val}, 32'd0);
    con_q.delete();
    cyc();
    repeat (2) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("fl_after_wait", {30'd0, in_rdy, out_val}, 32'b10);
      cyc();
    end

    // WAIT timeout (aborts only when the feature is built in).
    push_frame();
    repeat (EXP) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_cu_start", {31'd0, cu_start}, 32'd1);
    cyc();
    for (int unsigned w = 1; w <= TO; w++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (w == TO) check("to_wait_last", {31'd0, in_rdy}, 32'd0);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_in_rdy", {31'd0, in_rdy}, {31'd0, TO_EN});
    check("to_err", {31'd0, timeout_err}, {31'd0, TO_EN});
    cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.delete(); con_q.delete();
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_err_cleared", {31'd0, timeout_err}, 32'd0);
    check("to_flush_fill", {31'd0, in_rdy}, 32'd1);
    cyc();

    check("sb_empty", exp_q.size() + con_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
